// File: rtl/ridecore_fetch_pkg.sv
// ridecore fetch front end: shared types, line geometry and slot helper.
// Imported by the fetch buffer, its line FIFO and its bus interface users.
package ridecore_fetch_pkg;

  localparam int LINE_BYTES = 16;
  localparam int SLOTS      = 4;

  typedef struct packed {
    logic [127:0] line;
    logic [31:0]  line_addr;
    logic [1:0]   start_slot;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE_EMPTY,
    STREAM,
    STALL_FULL
  } fetch_state_t;

  function automatic logic [31:0] slot_of(
    input logic [127:0] line,
    input logic [1:0]   idx
  );
    return line[{idx, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/ridecore_fetch_buffer_if.sv
// Fetch bus: imem line request/response, backend redirect, decode pair.
// master = fetch buffer side, slave = memory model / decode / backend side.
interface ridecore_fetch_buffer_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] imem_addr;
  logic [127:0]      imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_ready;
  logic              out_valid0;
  logic              out_valid1;
  logic [ADDR_W-1:0] out_inst0;
  logic [ADDR_W-1:0] out_inst1;
  logic [ADDR_W-1:0] out_pc0;
  logic [ADDR_W-1:0] out_pc1;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready,
    output out_valid0,
    output out_valid1,
    output out_inst0,
    output out_inst1,
    output out_pc0,
    output out_pc1
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    output out_ready,
    input  out_valid0,
    input  out_valid1,
    input  out_inst0,
    input  out_inst1,
    input  out_pc0,
    input  out_pc1
  );

endinterface

// File: rtl/ridecore_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush; head is shown combinationally.
// Ports: clk, reset, flush, push/push_data, pop, head, count, full, empty.
module ridecore_fetch_fifo
  import ridecore_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == PTR_W'(DEPTH));
  assign empty   = (wptr == rptr);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rptr[PTR_W-2:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wptr[PTR_W-2:0]] <= push_data;
  end

endmodule

// File: rtl/ridecore_fetch_buffer.sv
// Fetch buffer: streams 16B lines from imem into a FIFO, issues <=2 insts/cycle.
// Ports: clk, reset (sync, active high), bus (imem, redirect, decode pair).
module ridecore_fetch_buffer
  import ridecore_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  ridecore_fetch_buffer_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  fetch_entry_t      head;
  fetch_entry_t      push_data;
  logic [PTR_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              consume;
  logic              issue;
  logic              req_pending;
  logic [ADDR_W-1:0] req_line;
  logic [ADDR_W-1:0] fetch_addr;
  logic [1:0]        slot_ptr;
  logic [1:0]        start_next;
  logic [1:0]        cur;
  logic [2:0]        sum;
  logic [PTR_W:0]    inflight;
  logic              v0;
  logic              v1;
  logic [ADDR_W-1:0] pc0;
  fetch_state_t      state;
  logic              unused_bits;

  assign unused_bits = ^bus.redirect_pc[1:0];

  // Occupancy counts the in-flight line so a response always has room.
  assign inflight = {1'b0, count} + {{PTR_W{1'b0}}, req_pending};

  always_comb begin
    state = STREAM;
    unique case (1'b1)
      (inflight == '0):      state = IDLE_EMPTY;
      (inflight >= DEPTH_C): state = STALL_FULL;
      default:               state = STREAM;
    endcase
  end

  assign issue = !bus.redirect_valid && (state != STALL_FULL);

  assign push      = req_pending && !bus.redirect_valid;
  assign push_data = '{
    line:       bus.imem_data,
    line_addr:  req_line,
    start_slot: start_next
  };

  ridecore_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // slot_ptr restarts at 0 per line; the entry's start_slot lifts it
  // for the first line after a redirect.
  assign cur = (slot_ptr > head.start_slot) ? slot_ptr : head.start_slot;
  assign v0  = !empty;
  assign v1  = v0 && (cur != 2'd3);
  assign pc0 = head.line_addr + {{(ADDR_W-4){1'b0}}, cur, 2'b00};

  assign bus.imem_addr  = fetch_addr;
  assign bus.out_valid0 = v0;
  assign bus.out_valid1 = v1;
  assign bus.out_inst0  = v0 ? slot_of(head.line, cur) : '0;
  assign bus.out_inst1  = v1 ? slot_of(head.line, cur + 2'd1) : '0;
  assign bus.out_pc0    = v0 ? pc0 : '0;
  assign bus.out_pc1    = v1 ? pc0 + ADDR_W'(4) : '0;

  assign consume = bus.out_ready && v0 && !bus.redirect_valid;
  assign sum     = {1'b0, cur} + (v1 ? 3'd2 : 3'd1);
  assign pop     = consume && sum[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr  <= RESET_PC;
      req_pending <= 1'b0;
      req_line    <= '0;
      slot_ptr    <= 2'd0;
      start_next  <= 2'd0;
    end else if (bus.redirect_valid) begin
      fetch_addr  <= {bus.redirect_pc[ADDR_W-1:4], 4'b0};
      req_pending <= 1'b0;
      slot_ptr    <= 2'd0;
      start_next  <= bus.redirect_pc[3:2];
    end else begin
      req_pending <= issue;
      if (issue) begin
        req_line   <= fetch_addr;
        fetch_addr <= fetch_addr + ADDR_W'(LINE_BYTES);
      end
      if (req_pending) start_next <= 2'd0;
      if (pop)
        slot_ptr <= 2'd0;
      else if (consume)
        slot_ptr <= sum[1:0];
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (reset) !(push && full));
  a_v1_needs_v0: assert property (
    @(posedge clk) disable iff (reset) bus.out_valid1 |-> bus.out_valid0);
  a_addr_align: assert property (
    @(posedge clk) disable iff (reset) fetch_addr[3:0] == 4'd0);

endmodule

// File: tb/tb_ridecore_fetch_buffer.sv
// Directed bench for ridecore_fetch_buffer with a registered imem model.
// Each task drives a scenario and checks hand-derived outputs inline.
module tb_ridecore_fetch_buffer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ridecore_fetch_buffer_if bus ();

  ridecore_fetch_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [127:0] mk_line(input logic [31:0] a);
    return {inst_of(a + 32'd12), inst_of(a + 32'd8),
            inst_of(a + 32'd4), inst_of(a)};
  endfunction

  always @(posedge clk) bus.imem_data <= mk_line(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic rdy);
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.out_ready = rdy;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.out_valid0, bus.out_valid1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid got %b%b want 00",
               bus.out_valid0, bus.out_valid1);
    end
    checks++;
    if (bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0", bus.imem_addr);
    end
    checks++;
    if ({bus.out_inst0, bus.out_inst1, bus.out_pc0, bus.out_pc1} !== 128'h0)
    begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want 0",
               bus.out_inst0, bus.out_inst1, bus.out_pc0, bus.out_pc1);
    end
  endtask

  task automatic test_stream();
    logic [129:0] got;
    logic [129:0] exp;
    logic [31:0]  pc;
    start_stream(1'b1);
    checks++;
    if (bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL stream_addr0 got %h want 0", bus.imem_addr);
    end
    tick();
    checks++;
    if ({bus.out_valid0, bus.imem_addr} !== {1'b0, 32'h10}) begin
      errors++;
      $display("FAIL stream_c1 got v0=%b addr=%h want v0=0 addr=10",
               bus.out_valid0, bus.imem_addr);
    end
    tick();
    checks++;
    if (bus.imem_addr !== 32'h20) begin
      errors++;
      $display("FAIL stream_addr2 got %h want 20", bus.imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      pc  = 32'(k * 8);
      got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
             bus.out_inst0, bus.out_inst1};
      exp = {2'b11, pc, pc + 32'd4, inst_of(pc), inst_of(pc + 32'd4)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stream_pair%0d got %h want %h", k, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [129:0] got;
    logic [129:0] exp;
    logic [31:0]  pc;
    start_stream(1'b0);
    repeat (10) tick();
    checks++;
    if (bus.imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL bp_stuck_addr got %h want 40", bus.imem_addr);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pc  = 32'(k * 8);
      got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
             bus.out_inst0, bus.out_inst1};
      exp = {2'b11, pc, pc + 32'd4, inst_of(pc), inst_of(pc + 32'd4)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bp_pair%0d got %h want %h", k, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_redirect_pending();
    logic [129:0] got;
    logic [129:0] exp;
    start_stream(1'b1);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_1008;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if ({bus.out_valid0, bus.imem_addr} !== {1'b0, 32'h1000}) begin
      errors++;
      $display("FAIL redir_flush got v0=%b addr=%h want v0=0 addr=1000",
               bus.out_valid0, bus.imem_addr);
    end
    tick();
    checks++;
    if ({bus.out_valid0, bus.imem_addr} !== {1'b0, 32'h1010}) begin
      errors++;
      $display("FAIL redir_stale got v0=%b pc0=%h addr=%h want v0=0 addr=1010",
               bus.out_valid0, bus.out_pc0, bus.imem_addr);
    end
    tick();
    got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
           bus.out_inst0, bus.out_inst1};
    exp = {2'b11, 32'h1008, 32'h100C, inst_of(32'h1008), inst_of(32'h100C)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL redir_first got %h want %h", got, exp);
    end
    tick();
    got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
           bus.out_inst0, bus.out_inst1};
    exp = {2'b11, 32'h1010, 32'h1014, inst_of(32'h1010), inst_of(32'h1014)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL redir_second got %h want %h", got, exp);
    end
  endtask

  task automatic test_redirect_slot3();
    logic [129:0] got;
    logic [129:0] exp;
    logic [65:0]  g1;
    logic [65:0]  e1;
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_100C;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if ({bus.out_valid0, bus.imem_addr} !== {1'b0, 32'h1000}) begin
      errors++;
      $display("FAIL s3_flush got v0=%b addr=%h want v0=0 addr=1000",
               bus.out_valid0, bus.imem_addr);
    end
    repeat (2) tick();
    g1 = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_inst0};
    e1 = {2'b10, 32'h100C, inst_of(32'h100C)};
    checks++;
    if (g1 !== e1) begin
      errors++;
      $display("FAIL s3_alone got %h want %h", g1, e1);
    end
    tick();
    got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
           bus.out_inst0, bus.out_inst1};
    exp = {2'b11, 32'h1010, 32'h1014, inst_of(32'h1010), inst_of(32'h1014)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL s3_next got %h want %h", got, exp);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    tick();
    bus.redirect_pc = 32'h0000_3004;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if ({bus.out_valid0, bus.imem_addr} !== {1'b0, 32'h3000}) begin
      errors++;
      $display("FAIL last_wins_addr got v0=%b addr=%h want v0=0 addr=3000",
               bus.out_valid0, bus.imem_addr);
    end
    repeat (2) tick();
    got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
           bus.out_inst0, bus.out_inst1};
    exp = {2'b11, 32'h3004, 32'h3008, inst_of(32'h3004), inst_of(32'h3008)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL last_wins_pair got %h want %h", got, exp);
    end
    tick();
    g1 = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_inst0};
    e1 = {2'b10, 32'h300C, inst_of(32'h300C)};
    checks++;
    if (g1 !== e1) begin
      errors++;
      $display("FAIL slot1_tail got %h want %h", g1, e1);
    end
    tick();
    got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
           bus.out_inst0, bus.out_inst1};
    exp = {2'b11, 32'h3010, 32'h3014, inst_of(32'h3010), inst_of(32'h3014)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL slot1_next got %h want %h", got, exp);
    end
  endtask

  task automatic test_reset_redirect();
    logic [129:0] got;
    logic [129:0] exp;
    repeat (2) tick();
    reset = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_5000;
    tick();
    checks++;
    if ({bus.out_valid0, bus.out_valid1, bus.imem_addr} !== {2'b00, 32'h0})
    begin
      errors++;
      $display("FAIL rst_redir got v=%b%b addr=%h want v=00 addr=0",
               bus.out_valid0, bus.out_valid1, bus.imem_addr);
    end
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (2) tick();
    got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
           bus.out_inst0, bus.out_inst1};
    exp = {2'b11, 32'h0, 32'h4, inst_of(32'h0), inst_of(32'h4)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rst_redir_first got %h want %h", got, exp);
    end
  endtask

  task automatic test_wrap();
    logic [129:0] got;
    logic [129:0] exp;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.imem_addr !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL wrap_addr0 got %h want fffffff0", bus.imem_addr);
    end
    tick();
    checks++;
    if (bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr1 got %h want 0", bus.imem_addr);
    end
    tick();
    got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
           bus.out_inst0, bus.out_inst1};
    exp = {2'b11, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
           inst_of(32'hFFFF_FFF8), inst_of(32'hFFFF_FFFC)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wrap_top got %h want %h", got, exp);
    end
    tick();
    got = {bus.out_valid0, bus.out_valid1, bus.out_pc0, bus.out_pc1,
           bus.out_inst0, bus.out_inst1};
    exp = {2'b11, 32'h0, 32'h4, inst_of(32'h0), inst_of(32'h4)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wrap_zero got %h want %h", got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_pending();
    test_redirect_slot3();
    test_reset_redirect();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
